// File: rtl/rip_axi_master_ot_if.sv
// AXI4 bus bundle shared by the rip masters and the rip_axi_interface fabric.
// Widths are set per instance; the master/slave modports fix signal direction.
interface rip_axi_interface #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWLOCK;
    logic [3:0]            AWCACHE;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_W-1:0]     WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARLOCK;
    logic [3:0]            ARCACHE;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/rip_axi_master_ot.sv
// AXI4 master: one write burst at a time, up to MAX_OUTSTANDING read bursts in flight.
// Read data is streamed straight through from the R channel with caller backpressure.
module rip_axi_master_ot #(
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 0,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_BURST_LEN   = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_W           = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    output logic                                  wreq_ready,
    input  logic                                  wreq_valid,
    input  logic [ADDR_WIDTH-1:0]                 wreq_addr,
    input  logic [LEN_W-1:0]                      wreq_len,
    input  logic [DATA_WIDTH*MAX_BURST_LEN-1:0]   wreq_data,
    input  logic [DATA_WIDTH/8*MAX_BURST_LEN-1:0] wreq_strb,
    output logic                                  wdone,
    output logic [1:0]                            wresp,
    output logic                                  rreq_ready,
    input  logic                                  rreq_valid,
    input  logic [ADDR_WIDTH-1:0]                 rreq_addr,
    input  logic [LEN_W-1:0]                      rreq_len,
    output logic                                  rbeat_valid,
    input  logic                                  rbeat_ready,
    output logic [DATA_WIDTH-1:0]                 rbeat_data,
    output logic                                  rbeat_last,
    output logic [1:0]                            rbeat_resp,
    output logic [OUT_W-1:0]                      rd_outstanding,
    rip_axi_interface.master                      AXIM
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_e;

    wstate_e                                   wstate_q, wstate_d;
    logic                                      awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0]                     awaddr_q, awaddr_d;
    logic [7:0]                                awlen_q, awlen_d;
    logic                                      wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]                     wdata_q, wdata_d;
    logic [STRB_W-1:0]                         wstrb_q, wstrb_d;
    logic                                      wlast_q, wlast_d;
    logic                                      bready_q, bready_d;
    logic [MAX_BURST_LEN-1:0][DATA_WIDTH-1:0]  wbuf_data_q, wbuf_data_d;
    logic [MAX_BURST_LEN-1:0][STRB_W-1:0]      wbuf_strb_q, wbuf_strb_d;
    logic [LEN_W-1:0]                          wlen_q, wlen_d;
    logic [LEN_W-1:0]                          beat_cnt_q, beat_cnt_d;
    logic                                      aw_done_q, aw_done_d;
    logic                                      w_done_q, w_done_d;
    logic                                      wdone_q, wdone_d;
    logic [1:0]                                wresp_q, wresp_d;

    logic                                      arvalid_q;
    logic [ADDR_WIDTH-1:0]                     araddr_q;
    logic [7:0]                                arlen_q;
    logic [OUT_W-1:0]                          rd_out_q, rd_out_d;

    logic aw_fire, w_fire, ar_fire, r_last_fire, rd_dec;

    assign aw_fire     = awvalid_q & AXIM.AWREADY;
    assign w_fire      = wvalid_q & AXIM.WREADY;
    assign ar_fire     = arvalid_q & AXIM.ARREADY;
    assign r_last_fire = AXIM.RVALID & rbeat_ready & AXIM.RLAST;
    // A stray RLAST with nothing in flight is a slave protocol error and is dropped.
    assign rd_dec      = r_last_fire & (rd_out_q != '0);

    assign wreq_ready = (wstate_q == W_IDLE);
    assign wdone      = wdone_q;
    assign wresp      = wresp_q;

    always_comb begin
        wstate_d    = wstate_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wlast_d     = wlast_q;
        bready_d    = bready_q;
        wbuf_data_d = wbuf_data_q;
        wbuf_strb_d = wbuf_strb_q;
        wlen_d      = wlen_q;
        beat_cnt_d  = beat_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        wdone_d     = 1'b0;
        wresp_d     = wresp_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (wreq_valid) begin
                    wbuf_data_d = wreq_data;
                    wbuf_strb_d = wreq_strb;
                    wlen_d      = wreq_len;
                    awaddr_d    = wreq_addr;
                    awlen_d     = 8'(wreq_len);
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    wdata_d     = wreq_data[DATA_WIDTH-1:0];
                    wstrb_d     = wreq_strb[STRB_W-1:0];
                    wlast_d     = (wreq_len == '0);
                    beat_cnt_d  = LEN_W'(1);
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    wstate_d    = W_XFER;
                end
            end
            W_XFER: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        wdata_d    = wbuf_data_q[beat_cnt_q];
                        wstrb_d    = wbuf_strb_q[beat_cnt_q];
                        wlast_d    = (beat_cnt_q == wlen_q);
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                // AW and the last W may finish in either order or together.
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (AXIM.BVALID) begin
                    bready_d = 1'b0;
                    wdone_d  = 1'b1;
                    wresp_d  = AXIM.BRESP;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q    <= W_IDLE;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            wbuf_data_q <= '0;
            wbuf_strb_q <= '0;
            wlen_q      <= '0;
            beat_cnt_q  <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            wdone_q     <= 1'b0;
            wresp_q     <= 2'b00;
        end else begin
            wstate_q    <= wstate_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            wbuf_data_q <= wbuf_data_d;
            wbuf_strb_q <= wbuf_strb_d;
            wlen_q      <= wlen_d;
            beat_cnt_q  <= beat_cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            wdone_q     <= wdone_d;
            wresp_q     <= wresp_d;
        end
    end

    // Only one AR can be pending, so the counter can never pass MAX_OUTSTANDING.
    assign rreq_ready = !arvalid_q && (rd_out_q < OUT_W'(MAX_OUTSTANDING));

    always_comb begin
        rd_out_d = rd_out_q;
        unique case ({ar_fire, rd_dec})
            2'b10:   rd_out_d = rd_out_q + 1'b1;
            2'b01:   rd_out_d = rd_out_q - 1'b1;
            default: rd_out_d = rd_out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            rd_out_q  <= '0;
        end else begin
            if (rreq_valid && rreq_ready) begin
                arvalid_q <= 1'b1;
                araddr_q  <= rreq_addr;
                arlen_q   <= 8'(rreq_len);
            end else if (ar_fire) begin
                arvalid_q <= 1'b0;
            end
            rd_out_q <= rd_out_d;
        end
    end

    assign rd_outstanding = rd_out_q;

    assign AXIM.AWID    = ID_WIDTH'(AXI_ID);
    assign AXIM.AWADDR  = awaddr_q;
    assign AXIM.AWLEN   = awlen_q;
    assign AXIM.AWSIZE  = 3'($clog2(STRB_W));
    assign AXIM.AWBURST = 2'b01;
    assign AXIM.AWLOCK  = 1'b0;
    assign AXIM.AWCACHE = 4'b0000;
    assign AXIM.AWPROT  = 3'b000;
    assign AXIM.AWVALID = awvalid_q;
    assign AXIM.WDATA   = wdata_q;
    assign AXIM.WSTRB   = wstrb_q;
    assign AXIM.WLAST   = wlast_q;
    assign AXIM.WVALID  = wvalid_q;
    assign AXIM.BREADY  = bready_q;

    assign AXIM.ARID    = ID_WIDTH'(AXI_ID);
    assign AXIM.ARADDR  = araddr_q;
    assign AXIM.ARLEN   = arlen_q;
    assign AXIM.ARSIZE  = 3'($clog2(STRB_W));
    assign AXIM.ARBURST = 2'b01;
    assign AXIM.ARLOCK  = 1'b0;
    assign AXIM.ARCACHE = 4'b0000;
    assign AXIM.ARPROT  = 3'b000;
    assign AXIM.ARVALID = arvalid_q;

    assign AXIM.RREADY  = rbeat_ready;
    assign rbeat_valid  = AXIM.RVALID;
    assign rbeat_data   = AXIM.RDATA;
    assign rbeat_last   = AXIM.RLAST;
    assign rbeat_resp   = AXIM.RRESP;
endmodule

// File: tb/tb_rip_axi_master_ot.sv
// Randomized bench for rip_axi_master_ot: the bench plays the AXI slave and keeps a
// transaction-level model of bursts in flight to predict every observable output.
module tb_rip_axi_master_ot;
    localparam int IDW = 4, AW = 32, DW = 32, MBL = 8, MOT = 4, LW = 3, OW = 3, SW = DW / 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            wreq_ready, wreq_valid, wdone;
    logic [AW-1:0]   wreq_addr;
    logic [LW-1:0]   wreq_len;
    logic [DW*MBL-1:0] wreq_data;
    logic [SW*MBL-1:0] wreq_strb;
    logic [1:0]      wresp;
    logic            rreq_ready, rreq_valid;
    logic [AW-1:0]   rreq_addr;
    logic [LW-1:0]   rreq_len;
    logic            rbeat_valid, rbeat_ready, rbeat_last;
    logic [DW-1:0]   rbeat_data;
    logic [1:0]      rbeat_resp;
    logic [OW-1:0]   rd_outstanding;

    rip_axi_interface #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    rip_axi_master_ot #(
        .ID_WIDTH(IDW), .AXI_ID(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MOT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wreq_ready(wreq_ready), .wreq_valid(wreq_valid), .wreq_addr(wreq_addr),
        .wreq_len(wreq_len), .wreq_data(wreq_data), .wreq_strb(wreq_strb),
        .wdone(wdone), .wresp(wresp),
        .rreq_ready(rreq_ready), .rreq_valid(rreq_valid), .rreq_addr(rreq_addr),
        .rreq_len(rreq_len),
        .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready), .rbeat_data(rbeat_data),
        .rbeat_last(rbeat_last), .rbeat_resp(rbeat_resp),
        .rd_outstanding(rd_outstanding),
        .AXIM(axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read-side model: bursts whose AR has completed, in issue order (single ID).
    int          bq[$];
    int          exp_cnt = 0;
    bit          exp_arp = 0;
    logic [31:0] exp_araddr = '0;
    int          exp_arlen = 0;
    int          rbeat = 0;
    bit          rvh = 0;
    bit          req_acc = 0;
    int          both_events = 0;

    task automatic run_write(input logic [31:0] addr, input int len, input logic [DW*MBL-1:0] data,
                             input logic [SW*MBL-1:0] strb, input logic [1:0] bresp,
                             input int aw_dly, input int wr_pct);
        int wi = 0, aw_cnt = 0, dones = 0, cyc = 0;
        bit aw_got = 0, b_got = 0, bv = 0, bready_seen = 0;
        @(negedge clk);
        wreq_valid = 1'b1; wreq_addr = addr; wreq_len = LW'(len);
        wreq_data = data; wreq_strb = strb;
        #1 check("wreq_ready_idle", wreq_ready, 1);
        @(negedge clk);
        wreq_valid = 1'b0;
        while (!b_got && cyc < 300) begin
            axi.AWREADY = (cyc >= aw_dly);
            axi.WREADY  = ($urandom_range(99) < wr_pct);
            axi.BVALID  = bv;
            axi.BRESP   = bresp;
            #1;
            if (wdone) dones++;
            if (wreq_ready) check("wreq_ready_busy", wreq_ready, 0);
            if (axi.BREADY && !bready_seen) begin
                check("bready_after_aw_w", {aw_got, (wi == len + 1)}, 2'b11);
                bready_seen = 1;
            end
            if (axi.AWVALID && axi.AWREADY) begin
                aw_cnt++;
                check("awaddr", axi.AWADDR, addr);
                check("awlen", axi.AWLEN, len);
                check("awsize_burst_id", {axi.AWSIZE, axi.AWBURST, axi.AWID}, {3'd2, 2'b01, 4'd0});
                aw_got = 1;
            end
            if (axi.WVALID && axi.WREADY) begin
                if (wi > len) check("w_extra_beat", wi, len);
                else begin
                    check("wdata", axi.WDATA, data[wi*DW +: DW]);
                    check("wstrb", axi.WSTRB, strb[wi*SW +: SW]);
                    check("wlast", axi.WLAST, (wi == len));
                end
                wi++;
            end
            if (axi.BVALID && axi.BREADY) b_got = 1;
            if (aw_got && wi == len + 1 && $urandom_range(1) == 1) bv = 1;
            @(negedge clk);
            cyc++;
        end
        axi.BVALID = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        check("b_handshake_seen", b_got, 1);
        #1;
        check("wdone_pulse", wdone, 1);
        check("wresp", wresp, bresp);
        check("aw_count", aw_cnt, 1);
        check("w_beat_count", wi, len + 1);
        check("early_wdone", dones, 0);
        @(negedge clk);
        #1 check("wdone_one_cycle", wdone, 0);
    endtask

    task automatic run_reads(input int cycles, input int req_pct, input int arr_pct,
                             input int rv_pct, input int rr_pct);
        bit arf, rf, rlf;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (req_acc) rreq_valid = 1'b0;
            req_acc = 0;
            if (!rreq_valid && $urandom_range(99) < req_pct) begin
                rreq_valid = 1'b1;
                rreq_addr  = $urandom;
                rreq_len   = LW'($urandom_range(0, MBL - 1));
            end
            axi.ARREADY = ($urandom_range(99) < arr_pct);
            if (!rvh) begin
                if (bq.size() > 0 && $urandom_range(99) < rv_pct) begin
                    axi.RVALID = 1'b1;
                    axi.RDATA  = $urandom;
                    axi.RRESP  = 2'($urandom_range(0, 3));
                    axi.RLAST  = (rbeat == bq[0]);
                    rvh = 1;
                end else begin
                    axi.RVALID = 1'b0;
                    axi.RLAST  = 1'b0;
                end
            end
            rbeat_ready = ($urandom_range(99) < rr_pct);
            #1;
            check("rd_outstanding", rd_outstanding, exp_cnt);
            check("rreq_ready", rreq_ready, (!exp_arp && exp_cnt < MOT));
            check("arvalid", axi.ARVALID, exp_arp);
            if (exp_arp) begin
                check("araddr", axi.ARADDR, exp_araddr);
                check("arlen", axi.ARLEN, exp_arlen);
            end
            check("rready", axi.RREADY, rbeat_ready);
            check("rbeat_valid", rbeat_valid, axi.RVALID);
            if (axi.RVALID)
                check("rbeat_fields", {rbeat_data, rbeat_last, rbeat_resp},
                      {axi.RDATA, axi.RLAST, axi.RRESP});
            arf = exp_arp && axi.ARREADY;
            rf  = axi.RVALID && rbeat_ready;
            rlf = rf && axi.RLAST;
            if (arf && rlf) both_events++;
            if (rreq_valid && !exp_arp && exp_cnt < MOT) begin
                req_acc = 1;
                exp_arp = 1; exp_araddr = rreq_addr; exp_arlen = int'(rreq_len);
            end else if (arf) begin
                bq.push_back(exp_arlen);
                exp_arp = 0;
            end
            if (rf) begin
                rvh = 0;
                if (rlf) begin void'(bq.pop_front()); rbeat = 0; end
                else rbeat++;
            end
            exp_cnt = bq.size();
        end
    endtask

    initial begin
        logic [DW*MBL-1:0] d;
        logic [SW*MBL-1:0] s;
        int len;
        wreq_valid = 0; wreq_addr = '0; wreq_len = '0; wreq_data = '0; wreq_strb = '0;
        rreq_valid = 0; rreq_addr = '0; rreq_len = '0; rbeat_ready = 0;
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0; axi.BID = '0;
        axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = 0; axi.RLAST = 0; axi.RID = '0;
        repeat (3) @(negedge clk);
        check("rst_axi_valids", {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID}, 4'b0);
        check("rst_wdone_wresp", {wdone, wresp}, 3'b0);
        check("rst_rd_outstanding", rd_outstanding, 0);
        rstn = 1'b1;
        #1 check("wreq_ready_after_reset", wreq_ready, 1);

        d = '0; d[31:0] = 32'hDEADBEEF;
        s = '0; s[3:0] = 4'h3;
        run_write(32'h100, 0, d, s, 2'b00, 0, 100);
        for (int i = 0; i < MBL; i++) d[i*DW +: DW] = $urandom;
        s = {MBL*SW{1'b1}};
        run_write(32'h200, 3, d, s, 2'b10, 5, 50);
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < MBL; i++) d[i*DW +: DW] = $urandom;
            for (int i = 0; i < MBL; i++) s[i*SW +: SW] = SW'($urandom);
            len = $urandom_range(0, MBL - 1);
            run_write($urandom, len, d, s, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 5), $urandom_range(30, 100));
        end

        run_reads(12, 100, 100, 0, 50);
        check("rd_full", rd_outstanding, MOT);
        run_reads(1500, 60, 60, 60, 60);
        run_reads(400, 0, 100, 100, 100);
        check("rd_drained", rd_outstanding, 0);
        @(negedge clk);
        rreq_valid = 1'b0;
        axi.RVALID = 1'b1; axi.RLAST = 1'b1; rbeat_ready = 1'b1;
        @(negedge clk);
        axi.RVALID = 1'b0; axi.RLAST = 1'b0; rbeat_ready = 1'b0;
        #1 check("rd_no_underflow", rd_outstanding, 0);

        @(negedge clk);
        wreq_valid = 1'b1; wreq_addr = 32'h300; wreq_len = 3'd3;
        @(negedge clk);
        wreq_valid = 1'b0;
        #1 check("midburst_valids", {axi.AWVALID, axi.WVALID}, 2'b11);
        #2 rstn = 1'b0;
        #1 check("async_rst_valids", {axi.AWVALID, axi.WVALID, axi.BREADY}, 3'b0);
        check("async_rst_wdone", wdone, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("wreq_ready_release", wreq_ready, 1);
        @(posedge clk);
        #1 check("idle_after_release", {wreq_ready, axi.AWVALID, axi.WVALID, wdone}, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
